// File: rtl/stream_net_pkg.sv
// Shared helpers for the stream network switch points.
// Provides default-configuration index types and the wrapping
// round-robin increment used by every arbitration lane.
package stream_net_pkg;

  localparam int unsigned def_num_inp = 4;
  localparam int unsigned def_num_out = 4;

  // Index of an input / output in the default 4x4 configuration
  typedef logic [$clog2(def_num_inp)-1:0] idx_inp_t;
  typedef logic [$clog2(def_num_out)-1:0] sel_oup_t;

  // Increment that wraps at n, valid for non-power-of-two n
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/stream_switch_arb_lane.sv
// One output's arbiter: round-robin pointer, lock-in state and rotating
// priority search over the requests targeting this output.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i  - clock / reset / state clear
//   req_i   [NumInp]   - requests targeting this output
//   rr_i    [IdxWidth] - external search start (ExtPrio only)
//   ready_i            - downstream ready of this output
//   valid_c            - combinational output valid
//   idx_c   [IdxWidth] - combinational granted input, 0 when idle
module stream_switch_arb_lane
  import stream_net_pkg::*;
#(
  parameter int unsigned NumInp   = 4,
  parameter bit          LockIn   = 1'b1,
  parameter bit          ExtPrio  = 1'b0,
  parameter int unsigned IdxWidth = $clog2(NumInp)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [NumInp-1:0]   req_i,
  input  logic [IdxWidth-1:0] rr_i,
  input  logic                ready_i,
  output logic                valid_c,
  output logic [IdxWidth-1:0] idx_c
);

  logic [IdxWidth-1:0] rr_q, rr_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] start;
  logic [IdxWidth-1:0] grant;
  logic                found;
  logic [IdxWidth-1:0] cand;

  // Rotating search from start, overridden by a still-requesting lock owner
  always_comb begin
    start = ExtPrio ? rr_i : rr_q;
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      cand = IdxWidth'((32'(start) + k) % NumInp);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    // A lock whose owner dropped its request is ignored
    if (lock_q && req_i[lock_idx_q]) begin
      grant = lock_idx_q;
    end
  end

  assign valid_c = |req_i;
  assign idx_c   = valid_c ? grant : '0;

  // Pointer and lock update; flush overrides the normal update
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (valid_c && ready_i) begin
      lock_d = 1'b0;
      if (!ExtPrio) begin
        rr_d = IdxWidth'(rr_next(32'(grant), NumInp));
      end
    end else if (valid_c && LockIn) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
    if (flush_i) begin
      rr_d       = '0;
      lock_d     = 1'b0;
      lock_idx_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/stream_switch_arbiter.sv
// Per-output round-robin arbitration with lock-in for one crossbar switch
// point. The payload mux lives outside and is steered by oup_idx_o.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i - clock / reset / state clear
//   rr_i        [NumOut][IdxWidth] - external start per output (ExtPrio)
//   sel_i       [NumInp][SelWidth] - target output per input
//   valid_i     [NumInp]           - input requests
//   ready_o     [NumInp]           - input handshake (combinational)
//   oup_valid_o [NumOut]           - output valid (combinational)
//   oup_idx_o   [NumOut][IdxWidth] - granted input per output (combinational)
//   oup_ready_i [NumOut]           - downstream ready
module stream_switch_arbiter
  import stream_net_pkg::*;
#(
  parameter int unsigned NumInp   = 4,
  parameter int unsigned NumOut   = 4,
  parameter bit          LockIn   = 1'b1,
  parameter bit          ExtPrio  = 1'b0,
  parameter int unsigned IdxWidth = $clog2(NumInp),
  parameter int unsigned SelWidth = $clog2(NumOut)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic [NumOut-1:0][IdxWidth-1:0]  rr_i,
  input  logic [NumInp-1:0][SelWidth-1:0]  sel_i,
  input  logic [NumInp-1:0]                valid_i,
  output logic [NumInp-1:0]                ready_o,
  output logic [NumOut-1:0]                oup_valid_o,
  output logic [NumOut-1:0][IdxWidth-1:0]  oup_idx_o,
  input  logic [NumOut-1:0]                oup_ready_i
);

  logic [NumOut-1:0][NumInp-1:0] req;

  // Request matrix; a select beyond NumOut matches no output
  always_comb begin
    req = '0;
    for (int unsigned j = 0; j < NumOut; j++) begin
      for (int unsigned i = 0; i < NumInp; i++) begin
        req[j][i] = valid_i[i] && (sel_i[i] == SelWidth'(j));
      end
    end
  end

  for (genvar j = 0; j < NumOut; j++) begin : g_lane
    stream_switch_arb_lane #(
      .NumInp  (NumInp),
      .LockIn  (LockIn),
      .ExtPrio (ExtPrio),
      .IdxWidth(IdxWidth)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .flush_i(flush_i),
      .req_i  (req[j]),
      .rr_i   (rr_i[j]),
      .ready_i(oup_ready_i[j]),
      .valid_c(oup_valid_o[j]),
      .idx_c  (oup_idx_o[j])
    );
  end

  // An input is ready when it owns its selected output and that output is ready
  always_comb begin
    ready_o = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      for (int unsigned j = 0; j < NumOut; j++) begin
        if (req[j][i] && oup_ready_i[j] && (oup_idx_o[j] == IdxWidth'(i))) begin
          ready_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_switch_arbiter.sv
// Directed bench: default 4x4 instance, an ExtPrio instance and a 4x3 instance.
module tb_stream_switch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, no_flush;

  // Default 4x4, LockIn, internal pointers
  logic [3:0][1:0] rr, sel, oidx;
  logic [3:0]      valid, ready, ov, ordy;

  // 4x4 with external priority
  logic [3:0][1:0] e_rr, e_sel, e_oidx;
  logic [3:0]      e_valid, e_ready, e_ov, e_ordy;

  // 4 inputs, 3 outputs
  logic [2:0][1:0] t_rr, t_oidx;
  logic [3:0][1:0] t_sel;
  logic [3:0]      t_valid, t_ready;
  logic [2:0]      t_ov, t_ordy;

  int n_checks = 0;
  int n_errors = 0;

  stream_switch_arbiter dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .rr_i(rr), .sel_i(sel),
    .valid_i(valid), .ready_o(ready), .oup_valid_o(ov), .oup_idx_o(oidx),
    .oup_ready_i(ordy)
  );

  stream_switch_arbiter #(.ExtPrio(1'b1)) dut_ext (
    .clk_i(clk), .rst_i(rst), .flush_i(no_flush), .rr_i(e_rr), .sel_i(e_sel),
    .valid_i(e_valid), .ready_o(e_ready), .oup_valid_o(e_ov), .oup_idx_o(e_oidx),
    .oup_ready_i(e_ordy)
  );

  stream_switch_arbiter #(.NumOut(3)) dut_3 (
    .clk_i(clk), .rst_i(rst), .flush_i(no_flush), .rr_i(t_rr), .sel_i(t_sel),
    .valid_i(t_valid), .ready_o(t_ready), .oup_valid_o(t_ov), .oup_idx_o(t_oidx),
    .oup_ready_i(t_ordy)
  );

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; no_flush = 1'b0;
    rr = '0; sel = '0; valid = '0; ordy = '0;
    e_rr = '0; e_sel = '0; e_valid = '0; e_ordy = '0;
    t_rr = '0; t_sel = '0; t_valid = '0; t_ordy = '0;

    // Idle outputs with no requests
    #1;
    check("idle_valid", 32'(ov), 0);
    check("idle_idx",   32'(oidx), 0);
    check("idle_ready", 32'(ready), 0);

    // Reset held with every input requesting output 0
    valid = 4'b1111;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Rotation: all four inputs on output 0, always ready
    ordy = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rot_idx",   32'(oidx[0]), k % 4);
      check("rot_ready", 32'(ready), 32'(1) << (k % 4));
      check("rot_valid", 32'(ov), 1);
      next_cycle();
    end

    // Lock-in on output 3: input 1 wins and stays granted while stalled
    valid = 4'b0110; sel = '0; sel[1] = 2'd3; sel[2] = 2'd3; ordy = 4'b0000;
    #1;
    check("lock_c1_idx",   32'(oidx[3]), 1);
    check("lock_c1_ready", 32'(ready), 0);
    next_cycle();
    // Input 0 joins; without the lock it would win from pointer 0
    valid = 4'b0111; sel[0] = 2'd3;
    #1;
    check("lock_c2_idx", 32'(oidx[3]), 1);
    check("lock_c2_ready", 32'(ready), 0);
    next_cycle();
    #1;
    check("lock_c3_idx", 32'(oidx[3]), 1);
    next_cycle();
    ordy = 4'b1000;
    #1;
    check("lock_c4_idx",   32'(oidx[3]), 1);
    check("lock_c4_ready", 32'(ready), 32'b0010);
    next_cycle();
    #1;
    check("lock_next_idx",   32'(oidx[3]), 2);
    check("lock_next_ready", 32'(ready), 32'b0100);
    next_cycle();

    // Flush mid-lock: pointer 3, lock on input 1, then flush
    valid = 4'b0110; ordy = 4'b0000;
    #1;
    check("flush_pre_idx", 32'(oidx[3]), 1);
    next_cycle();
    valid = 4'b0000; flush = 1'b1;
    #1;
    check("flush_cyc_valid", 32'(ov), 0);
    next_cycle();
    flush = 1'b0; valid = 4'b1011; sel = {2'd3, 2'd3, 2'd3, 2'd3}; ordy = 4'b1000;
    #1;
    check("flush_post_idx",   32'(oidx[3]), 0);
    check("flush_post_ready", 32'(ready), 32'b0001);
    next_cycle();
    valid = 4'b0000; ordy = 4'b0000;

    // ExtPrio: start index 2, inputs 0 and 3 on output 0
    e_rr[0] = 2'd2; e_valid = 4'b1001; e_ordy = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ext_idx",   32'(e_oidx[0]), 3);
      check("ext_ready", 32'(e_ready), 32'b1000);
      next_cycle();
    end
    e_rr[0] = 2'd0;
    #1;
    check("ext_start0_idx", 32'(e_oidx[0]), 0);
    next_cycle();
    e_rr[0] = 2'd1;
    #1;
    check("ext_start1_idx", 32'(e_oidx[0]), 3);
    next_cycle();
    e_valid = 4'b0000;

    // Illegal select alone on the 3-output instance
    t_sel[0] = 2'd3; t_valid = 4'b0001; t_ordy = 3'b111;
    #1;
    check("illegal_valid", 32'(t_ov), 0);
    check("illegal_ready", 32'(t_ready), 0);
    next_cycle();

    // Illegal select alongside two concurrent transfers
    t_sel[1] = 2'd0; t_sel[2] = 2'd1; t_valid = 4'b0111;
    #1;
    check("par_valid", 32'(t_ov), 32'b011);
    check("par_ready", 32'(t_ready), 32'b0110);
    check("par_idx0",  32'(t_oidx[0]), 1);
    check("par_idx1",  32'(t_oidx[1]), 2);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
